// File: rtl/pw_ctrl_pkg.sv
// Shared definitions for the password-entry sequencer.
//   pw_state_e : FSM state encoding, also driven out on state_out.
//   KEY_*      : index of each push-button in key_n and in the event vector.
package pw_ctrl_pkg;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    CHECK   = 3'd1,
    GRANTED = 3'd2,
    DENIED  = 3'd3,
    LOCKED  = 3'd4
  } pw_state_e;

  localparam int KEY_DIGIT  = 0;
  localparam int KEY_SUBMIT = 1;
  localparam int KEY_CLEAR  = 2;
  localparam int NUM_KEYS   = 3;

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one active-low push-button.
//   gclk  : clock (rising edge)
//   rst   : asynchronous active-high reset, debouncer comes up released
//   key_n : raw button, active low
//   press : one-cycle pulse when the debounced level goes 1 -> 0
// The debounced level follows the synchronized input only after it has held a
// new value for DEBOUNCE_CYCLES consecutive samples; a sample that matches the
// current level again clears the run. Press latency from a clean raw edge is
// DEBOUNCE_CYCLES+2 (two synchronizer stages, then the run length).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic gclk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2, level;
  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        // old level 1 means this flip is the press edge; releases stay silent
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/password_check_ctrl.sv
// Password-entry sequencer.
//   ref_clk_clk / ref_reset_reset : clock, asynchronous active-high reset
//   key_n[2:0]   : raw buttons (digit, submit, clear), active low; [3] unused
//   digit_in     : BCD digit from the switches
//   pw_wr/pw_data: one-cycle load of a new stored password (first digit in MSN)
//   entry_digits/entry_count : digits collected so far
//   state_out, granted, denied, locked, tries_left : registered status
module password_check_ctrl
  import pw_ctrl_pkg::*;
#(
  parameter int                    PW_LEN          = 4,
  parameter logic [4*PW_LEN-1:0]   DEFAULT_PW      = 16'h1234,
  parameter int                    DEBOUNCE_CYCLES = 1000000,
  parameter int                    MAX_TRIES       = 3,
  parameter int                    SHOW_CYCLES     = 100000000,
  parameter int                    LOCK_CYCLES     = 500000000
) (
  input  logic                               ref_clk_clk,
  input  logic                               ref_reset_reset,
  input  logic [3:0]                         key_n,
  input  logic [3:0]                         digit_in,
  input  logic                               pw_wr,
  input  logic [4*PW_LEN-1:0]                pw_data,
  output logic [4*PW_LEN-1:0]                entry_digits,
  output logic [$clog2(PW_LEN+1)-1:0]        entry_count,
  output logic [2:0]                         state_out,
  output logic                               granted,
  output logic                               denied,
  output logic                               locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left
);
  localparam int CW    = $clog2(PW_LEN + 1);
  localparam int TRW   = $clog2(MAX_TRIES + 1);
  localparam int MAX_T = (SHOW_CYCLES > LOCK_CYCLES) ? SHOW_CYCLES : LOCK_CYCLES;
  localparam int TMW   = $clog2(MAX_T + 1);

  logic [NUM_KEYS-1:0] key_evt;
  logic                unused_key;
  assign unused_key = key_n[3];

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_db
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .gclk  (ref_clk_clk),
      .rst   (ref_reset_reset),
      .key_n (key_n[k]),
      .press (key_evt[k])
    );
  end

  pw_state_e           state, state_nxt;
  logic [4*PW_LEN-1:0] stored_pw, digits_nxt;
  logic [CW-1:0]       count_nxt;
  logic [TRW-1:0]      tries_nxt;
  logic [TMW-1:0]      timer;

  assign state_out = state;

  always_comb begin
    state_nxt  = state;
    digits_nxt = entry_digits;
    count_nxt  = entry_count;
    tries_nxt  = tries_left;
    case (state)
      ENTRY: begin
        // clear > submit > digit; only the winner acts
        if (key_evt[KEY_CLEAR]) begin
          digits_nxt = '0;
          count_nxt  = '0;
        end else if (key_evt[KEY_SUBMIT]) begin
          if (entry_count == CW'(PW_LEN)) state_nxt = CHECK;
        end else if (key_evt[KEY_DIGIT] && entry_count < CW'(PW_LEN) &&
                     digit_in <= 4'd9) begin
          digits_nxt = {entry_digits[4*PW_LEN-5:0], digit_in};
          count_nxt  = entry_count + 1'b1;
        end
      end
      CHECK: begin
        digits_nxt = '0;
        count_nxt  = '0;
        // stored_pw is the pre-write value even if pw_wr fires this cycle
        if (entry_digits == stored_pw) begin
          state_nxt = GRANTED;
          tries_nxt = TRW'(MAX_TRIES);
        end else begin
          tries_nxt = tries_left - 1'b1;
          state_nxt = (tries_left == TRW'(1)) ? LOCKED : DENIED;
        end
      end
      GRANTED, DENIED: begin
        if (timer == TMW'(SHOW_CYCLES - 1)) state_nxt = ENTRY;
      end
      LOCKED: begin
        if (timer == TMW'(LOCK_CYCLES - 1)) begin
          state_nxt = ENTRY;
          tries_nxt = TRW'(MAX_TRIES);
        end
      end
      default: state_nxt = ENTRY;
    endcase
  end

  always_ff @(posedge ref_clk_clk or posedge ref_reset_reset) begin
    if (ref_reset_reset) begin
      state        <= ENTRY;
      entry_digits <= '0;
      entry_count  <= '0;
      tries_left   <= TRW'(MAX_TRIES);
      stored_pw    <= DEFAULT_PW;
      timer        <= '0;
      granted      <= 1'b0;
      denied       <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_nxt;
      entry_digits <= digits_nxt;
      entry_count  <= count_nxt;
      tries_left   <= tries_nxt;
      granted      <= (state_nxt == GRANTED);
      denied       <= (state_nxt == DENIED);
      locked       <= (state_nxt == LOCKED);
      if (pw_wr) stored_pw <= pw_data;
      // restart on every state change, saturate instead of wrapping
      if (state_nxt != state)  timer <= '0;
      else if (timer != '1)    timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_password_check_ctrl.sv
module tb_password_check_ctrl;
  import pw_ctrl_pkg::*;

  localparam int DB   = 4;
  localparam int SHOW = 8;
  localparam int LOCK = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_n = 4'hF;
  logic [3:0]  digit_in = 4'h0;
  logic        pw_wr = 1'b0;
  logic [15:0] pw_data = 16'h0;
  logic [15:0] entry_digits;
  logic [2:0]  entry_count;
  logic [2:0]  state_out;
  logic        granted, denied, locked;
  logic [1:0]  tries_left;

  password_check_ctrl #(
    .PW_LEN(4), .DEFAULT_PW(16'h1234), .DEBOUNCE_CYCLES(DB),
    .MAX_TRIES(3), .SHOW_CYCLES(SHOW), .LOCK_CYCLES(LOCK)
  ) dut (
    .ref_clk_clk(clk), .ref_reset_reset(rst), .key_n(key_n), .digit_in(digit_in),
    .pw_wr(pw_wr), .pw_data(pw_data), .entry_digits(entry_digits),
    .entry_count(entry_count), .state_out(state_out), .granted(granted),
    .denied(denied), .locked(locked), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // expected result of one submitted attempt; flags = {granted,denied,locked}
  typedef struct {
    logic [2:0] flags;
    logic [1:0] tries;
    int         dur;
    logic [1:0] tries_after;
    bit         cut;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_res(input logic [2:0] f, input logic [1:0] t, input int d,
                            input logic [1:0] ta, input bit cut);
    exp_t e;
    e.flags = f; e.tries = t; e.dur = d; e.tries_after = ta; e.cut = cut;
    exp_q.push_back(e);
  endtask

  // monitor: a rising result flag pops the next expectation
  logic [2:0] mon_prev_st = 3'd0;
  logic       mon_prev_any = 1'b0;
  initial begin
    exp_t e;
    int   n;
    forever begin
      @(negedge clk);
      if (!mon_prev_any && (granted | denied | locked)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {29'd0, granted, denied, locked}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("check_one_cycle", {29'd0, mon_prev_st}, 32'(CHECK));
          chk("result_flags", {29'd0, granted, denied, locked}, {29'd0, e.flags});
          chk("result_tries", {30'd0, tries_left}, {30'd0, e.tries});
          n = 0;
          while ((({granted, denied, locked} & e.flags) != 3'b000) && n < 100) begin
            n++;
            @(negedge clk);
          end
          if (!e.cut) begin
            chk("result_hold", n, e.dur);
            chk("return_state", {29'd0, state_out}, 32'(ENTRY));
            chk("return_count", {29'd0, entry_count}, 32'd0);
            chk("return_tries", {30'd0, tries_left}, {30'd0, e.tries_after});
          end
        end
      end
      mon_prev_any = granted | denied | locked;
      mon_prev_st  = state_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  task automatic press_key(input int k, input logic [3:0] d);
    digit_in = d;
    key_n[k] = 1'b0;
    repeat (DB + 4) @(negedge clk);
    key_n[k] = 1'b1;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic enter4(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) press_key(0, v[4*i +: 4]);
  endtask

  // hold submit until a result flag appears, then release
  task automatic submit_wait();
    int n = 0;
    key_n[1] = 1'b0;
    while (!(granted | denied | locked) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("result_timeout", n, 32'd0);
    key_n[1] = 1'b1;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (state_out != 3'(ENTRY) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", {29'd0, state_out}, 32'(ENTRY));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_state", {29'd0, state_out}, 32'(ENTRY));
    chk("rst_digits", {16'd0, entry_digits}, 32'd0);
    chk("rst_count", {29'd0, entry_count}, 32'd0);
    chk("rst_flags", {29'd0, granted, denied, locked}, 32'd0);
    chk("rst_tries", {30'd0, tries_left}, 32'd3);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: correct default password
    enter4(16'h1234);
    chk("t1_digits", {16'd0, entry_digits}, 32'h1234);
    chk("t1_count", {29'd0, entry_count}, 32'd4);
    expect_res(3'b100, 2'd3, SHOW, 2'd3, 1'b0);
    submit_wait();
    wait_idle();

    // 2: three wrong attempts -> lockout, presses ignored while locked
    enter4(16'h1235);
    expect_res(3'b010, 2'd2, SHOW, 2'd2, 1'b0);
    submit_wait();
    wait_idle();
    enter4(16'h1235);
    expect_res(3'b010, 2'd1, SHOW, 2'd1, 1'b0);
    submit_wait();
    wait_idle();
    enter4(16'h1235);
    expect_res(3'b001, 2'd0, LOCK, 2'd3, 1'b0);
    submit_wait();
    press_key(0, 4'd5);
    wait_idle();
    chk("t2_lock_ignored_count", {29'd0, entry_count}, 32'd0);
    chk("t2_lock_ignored_digits", {16'd0, entry_digits}, 32'd0);

    // 3: bouncing digit key -> exactly one digit
    digit_in = 4'd7;
    for (int i = 0; i < 6; i++) begin
      key_n[0] = ~key_n[0];
      repeat (2) @(negedge clk);
    end
    key_n[0] = 1'b0;
    repeat (DB + 4) @(negedge clk);
    key_n[0] = 1'b1;
    repeat (DB + 4) @(negedge clk);
    chk("t3_bounce_digits", {16'd0, entry_digits}, 32'h0007);
    chk("t3_bounce_count", {29'd0, entry_count}, 32'd1);
    press_key(2, 4'd0);
    chk("t3_clear_count", {29'd0, entry_count}, 32'd0);

    // 4: short submit, invalid digit, clear beats digit
    press_key(0, 4'd1);
    press_key(0, 4'd2);
    press_key(1, 4'd0);
    chk("t4_short_state", {29'd0, state_out}, 32'(ENTRY));
    chk("t4_short_count", {29'd0, entry_count}, 32'd2);
    chk("t4_short_digits", {16'd0, entry_digits}, 32'h0012);
    press_key(0, 4'hA);
    chk("t4_bad_digit_count", {29'd0, entry_count}, 32'd2);
    digit_in = 4'd5;
    key_n = 4'b1010;
    repeat (DB + 4) @(negedge clk);
    key_n = 4'hF;
    repeat (DB + 4) @(negedge clk);
    chk("t4_clr_digit_count", {29'd0, entry_count}, 32'd0);
    chk("t4_clr_digit_digits", {16'd0, entry_digits}, 32'd0);

    // 5: load new password
    pw_data = 16'h9876;
    pw_wr = 1'b1;
    @(negedge clk);
    pw_wr = 1'b0;
    enter4(16'h9876);
    expect_res(3'b100, 2'd3, SHOW, 2'd3, 1'b0);
    submit_wait();
    wait_idle();
    enter4(16'h1234);
    expect_res(3'b010, 2'd2, SHOW, 2'd2, 1'b0);
    submit_wait();
    wait_idle();

    // 6: reset in the middle of a lockout
    enter4(16'h1234);
    expect_res(3'b010, 2'd1, SHOW, 2'd1, 1'b0);
    submit_wait();
    wait_idle();
    enter4(16'h1234);
    expect_res(3'b001, 2'd0, LOCK, 2'd3, 1'b1);
    submit_wait();
    chk("t6_locked_before_rst", {31'd0, locked}, 32'd1);
    #1 rst = 1'b1;
    #2;
    chk("t6_rst_locked", {31'd0, locked}, 32'd0);
    chk("t6_rst_tries", {30'd0, tries_left}, 32'd3);
    chk("t6_rst_state", {29'd0, state_out}, 32'(ENTRY));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    enter4(16'h1234);
    expect_res(3'b100, 2'd3, SHOW, 2'd3, 1'b0);
    submit_wait();
    wait_idle();
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/password_check_ctrl.md
Name: password_check_ctrl

Overview:
- Hardware password-entry sequencer for the board-level password checker.
- Takes raw push-buttons and a 4-bit digit from the slide switches, debounces the buttons and collects a PW_LEN-digit entry.
- Compares the entry against a stored password, then drives granted/denied/lockout status to LEDs and HEX digit drivers.
- The Nios system loads the stored password through a one-cycle write strobe.

Parameters:
- PW_LEN, 4, number of BCD digits in a password.
- DEFAULT_PW, 16'h1234, stored password after reset (4*PW_LEN bits).
- DEBOUNCE_CYCLES, 1000000, clock cycles a key must be stable to register (20 ms at 50 MHz).
- MAX_TRIES, 3, wrong attempts allowed before lockout.
- SHOW_CYCLES, 100000000, hold time of the GRANTED/DENIED result.
- LOCK_CYCLES, 500000000, lockout duration.

Ports:
- ref_clk_clk  in  1  system clock; all logic uses the rising edge.
- ref_reset_reset  in  1  asynchronous, active-high reset.
- key_n  in  4  raw DE2 push-buttons, active-low. [0]=digit, [1]=submit, [2]=clear, [3]=unused.
- digit_in  in  4  digit value from switches[3:0].
- pw_wr  in  1  one-cycle strobe that loads pw_data as the new stored password.
- pw_data  in  4*PW_LEN  new password, first digit in the most significant nibble.
- entry_digits  out  4*PW_LEN  digits entered so far, for the HEX drivers.
- entry_count  out  $clog2(PW_LEN+1)  number of digits entered.
- state_out  out  3  current FSM state encoding.
- granted  out  1  high while in GRANTED.
- denied  out  1  high while in DENIED.
- locked  out  1  high while in LOCKED.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts.

Behaviour:
- Reset: clock and reset are fixed as one clock (ref_clk_clk) and asynchronous active-high reset (ref_reset_reset). Reset asserts immediately, mid-operation included:
  - state ENTRY; entry_digits 0; entry_count 0.
  - granted/denied/locked 0; tries_left MAX_TRIES.
  - stored password DEFAULT_PW; all timers 0.
  - debouncers in the released state.
- Outputs are registered.
- Debounce:
  - each key passes a 2-FF synchronizer, then a counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any sample change restarts the count.
  - A press (debounced 1->0 on key_n) produces exactly one 1-cycle event pulse. Release produces no event.
  - Event latency from a clean raw edge is DEBOUNCE_CYCLES+2 cycles.
- Event priority when several fire in the same cycle: clear > submit > digit. Only the winner acts.
- ENTRY state:
  - digit event with entry_count<PW_LEN and digit_in<=9: entry_digits <= {entry_digits[4*PW_LEN-5:0], digit_in}; count+1.
  - digit_in>9, or count==PW_LEN: digit event is ignored.
  - clear: entry_digits and count are set to 0.
  - submit with count==PW_LEN: go to CHECK. Submit with a short entry is ignored.
- CHECK (exactly 1 cycle):
  - entry_digits==stored: go to GRANTED; tries_left <= MAX_TRIES.
  - mismatch: tries_left decrements. If the result is 0, go to LOCKED; otherwise go to DENIED.
  - entry_digits and count clear on leaving CHECK.
- GRANTED and DENIED:
  - the corresponding flag is high for exactly SHOW_CYCLES cycles, then the FSM returns to ENTRY.
  - all key events are ignored.
- LOCKED:
  - locked is high for exactly LOCK_CYCLES cycles, then the FSM returns to ENTRY with tries_left <= MAX_TRIES.
  - all key events are ignored.
- pw_wr:
  - accepted in any state; the stored password updates on the next edge.
  - a pw_wr in the same cycle as CHECK leaves the comparison on the old value.
  - pw_wr does not change tries_left and does not end a lockout.
- Timers are sized $clog2 of the largest cycle parameter. They count from 0 on state entry and never wrap.

Decomposition:
- Package pw_ctrl_pkg holds:
  - state encoding: ENTRY=0, CHECK=1, GRANTED=2, DENIED=3, LOCKED=4.
  - key index constants: KEY_DIGIT=0, KEY_SUBMIT=1, KEY_CLEAR=2.
- Sub-module key_debounce contains synchronizer, stability counter and press pulse. It is parameterised by DEBOUNCE_CYCLES and instantiated 3 times.
- FSM, entry buffer, compare and timers live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, SHOW_CYCLES=8, LOCK_CYCLES=16):
1. Reset, enter 1,2,3,4, submit -> one CHECK cycle; granted=1 for 8 cycles; tries_left=3; then ENTRY with count 0.
2. Enter 1,2,3,5 and submit, three times -> denied with tries_left 2, then 1. The third attempt gives locked=1 for 16 cycles with all presses ignored; then ENTRY with tries_left=3.
3. key_n[0] toggles every 2 cycles for 12 cycles, then is held low with digit_in=7 -> exactly one digit accepted; entry_digits=16'h0007.
4. Enter 1,2, submit -> stays ENTRY, count 2. digit_in=4'hA press -> ignored. Clear and digit pressed in the same cycle -> count 0 only.
5. pw_wr with pw_data=16'h9876, then enter 9,8,7,6 -> granted. Then enter 1,2,3,4 -> denied, tries_left=2.
6. Assert ref_reset_reset mid-LOCKED -> locked=0, tries_left=3, state ENTRY without waiting for a clock edge. The stored password returns to 16'h1234.
